// File: rtl/card_score_tracker_if.sv
// Guess/card handshake bundle for card_score_tracker.
// The master offers guesses and dealt cards; the slave (the tracker) returns the ready flags.
interface card_score_tracker_if;
    logic       guess_valid_in;
    logic [1:0] guess_suit_in;
    logic [3:0] guess_rank_in;
    logic       guess_ready_out;
    logic       card_valid_in;
    logic [1:0] card_suit_in;
    logic [3:0] card_rank_in;
    logic       card_ready_out;

    modport master (
        output guess_valid_in,
        output guess_suit_in,
        output guess_rank_in,
        input  guess_ready_out,
        output card_valid_in,
        output card_suit_in,
        output card_rank_in,
        input  card_ready_out
    );

    modport slave (
        input  guess_valid_in,
        input  guess_suit_in,
        input  guess_rank_in,
        output guess_ready_out,
        input  card_valid_in,
        input  card_suit_in,
        input  card_rank_in,
        output card_ready_out
    );
endinterface

// File: rtl/card_score_tracker.sv
// Card guessing game: latch a guess, accept a dealt card, score suit/rank matches, hold the card in SHOW.
// Optional macro SCORE_SATURATE_EN: scores hold at 99 on a match instead of wrapping to 0.
module card_score_tracker #(
    parameter int unsigned HOLD_CYCLES = 'd100_000_000,
    parameter int unsigned ROUNDS      = 'd52
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start_in,
    card_score_tracker_if.slave        bus_if,
    output logic [1:0]                 suit,
    output logic [3:0]                 rank,
    output logic [6:0]                 suit_score,
    output logic [6:0]                 rank_score,
    output logic                       round_done_out,
    output logic                       game_over_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GUESS = 3'd1,
        S_DEAL  = 3'd2,
        S_SCORE = 3'd3,
        S_SHOW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // A zero hold is treated as one cycle so SHOW always has an exit edge.
    localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES > 32'd1) ? 32'(HOLD_CYCLES - 32'd1) : 32'd0;
    localparam logic [31:0] ROUNDS_W  = 32'(ROUNDS);
    localparam logic [6:0]  SCORE_MAX = 7'd99;

    function automatic logic [6:0] score_next(input logic [6:0] score, input logic hit);
        logic [6:0] result;
        if (!hit) begin
            result = score;
        end else if (score >= SCORE_MAX) begin
`ifdef SCORE_SATURATE_EN
            result = SCORE_MAX;
`else
            result = 7'd0;
`endif
        end else begin
            result = score + 7'd1;
        end
        return result;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start_acc;
    logic        w_guess_acc;
    logic        w_card_acc;
    logic        w_show_end;
    logic        w_rank_ok;
    logic [31:0] w_round_inc;

    logic [1:0]  r_guess_suit;
    logic [3:0]  r_guess_rank;
    logic [1:0]  r_suit;
    logic [3:0]  r_rank;
    logic [6:0]  r_suit_score;
    logic [6:0]  r_rank_score;
    logic [31:0] r_round_cnt;
    logic [31:0] r_hold_cnt;
    logic        r_score_pend;
    logic        r_suit_hit;
    logic        r_rank_hit;
    logic        r_round_done;
    logic        r_guess_ready;
    logic        r_card_ready;
    logic        r_game_over;

    assign w_rank_ok   = (bus_if.card_rank_in >= 4'd1) && (bus_if.card_rank_in <= 4'd13);
    assign w_round_inc = r_round_cnt + 32'd1;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake acceptance strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_guess_acc = 1'b0;
        w_card_acc  = 1'b0;
        w_show_end  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_GUESS;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_GUESS: begin
                if (bus_if.guess_valid_in && r_guess_ready) begin
                    w_guess_acc = 1'b1;
                    w_state_nxt = S_DEAL;
                end else begin
                    w_state_nxt = S_GUESS;
                end
            end
            S_DEAL: begin
                if (bus_if.card_valid_in && r_card_ready && w_rank_ok) begin
                    w_card_acc  = 1'b1;
                    w_state_nxt = S_SCORE;
                end else begin
                    w_state_nxt = S_DEAL;
                end
            end
            S_SCORE: begin
                w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (r_hold_cnt >= HOLD_LAST) begin
                    w_show_end  = 1'b1;
                    w_state_nxt = (w_round_inc == ROUNDS_W) ? S_DONE : S_GUESS;
                end else begin
                    w_state_nxt = S_SHOW;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latched guess and revealed card.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_guess_suit <= 2'd0;
            r_guess_rank <= 4'd0;
            r_suit       <= 2'd0;
            r_rank       <= 4'd0;
        end else begin
            if (w_guess_acc) begin
                r_guess_suit <= bus_if.guess_suit_in;
                r_guess_rank <= bus_if.guess_rank_in;
            end
            if (w_start_acc) begin
                r_suit <= 2'd0;
                r_rank <= 4'd0;
            end else if (w_card_acc) begin
                r_suit <= bus_if.card_suit_in;
                r_rank <= bus_if.card_rank_in;
            end
        end
    end

    // Hold timer for SHOW and the per-game round counter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_hold_cnt  <= 32'd0;
            r_round_cnt <= 32'd0;
        end else begin
            if (r_state == S_SCORE) begin
                r_hold_cnt <= 32'd0;
            end else if ((r_state == S_SHOW) && !w_show_end) begin
                r_hold_cnt <= r_hold_cnt + 32'd1;
            end
            if (w_start_acc) begin
                r_round_cnt <= 32'd0;
            end else if (w_show_end) begin
                r_round_cnt <= w_round_inc;
            end
        end
    end

    // Match flags are captured as SCORE exits and applied one edge later with the round_done pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_score_pend <= 1'b0;
            r_suit_hit   <= 1'b0;
            r_rank_hit   <= 1'b0;
            r_round_done <= 1'b0;
            r_suit_score <= 7'd0;
            r_rank_score <= 7'd0;
        end else begin
            r_score_pend <= (r_state == S_SCORE);
            r_suit_hit   <= (r_suit == r_guess_suit);
            r_rank_hit   <= (r_rank == r_guess_rank);
            r_round_done <= r_score_pend;
            if (w_start_acc) begin
                r_suit_score <= 7'd0;
                r_rank_score <= 7'd0;
            end else if (r_score_pend) begin
                r_suit_score <= score_next(r_suit_score, r_suit_hit);
                r_rank_score <= score_next(r_rank_score, r_rank_hit);
            end
        end
    end

    // Ready and game-over flags decoded from the next state so they track the state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_guess_ready <= 1'b0;
            r_card_ready  <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_guess_ready <= (w_state_nxt == S_GUESS);
            r_card_ready  <= (w_state_nxt == S_DEAL);
            r_game_over   <= (w_state_nxt == S_DONE);
        end
    end

    assign bus_if.guess_ready_out = r_guess_ready;
    assign bus_if.card_ready_out  = r_card_ready;
    assign suit           = r_suit;
    assign rank           = r_rank;
    assign suit_score     = r_suit_score;
    assign rank_score     = r_rank_score;
    assign round_done_out = r_round_done;
    assign game_over_out  = r_game_over;

endmodule

// File: tb/tb_card_score_tracker.sv
// Directed bench for card_score_tracker: one short game (HOLD 4, ROUNDS 2) and one long run for the 99 limit.
module tb_card_score_tracker;

    logic clk;
    logic rst_n;
    logic start_a;
    logic start_b;
    int   n_pass;
    int   n_total;
    int   pulses;
    logic [6:0] exp_limit;

    logic [1:0] suit_a, suit_b;
    logic [3:0] rank_a, rank_b;
    logic [6:0] suit_score_a, suit_score_b, rank_score_a, rank_score_b;
    logic       round_done_a, round_done_b, game_over_a, game_over_b;

    card_score_tracker_if if_a ();
    card_score_tracker_if if_b ();

    card_score_tracker #(.HOLD_CYCLES(4), .ROUNDS(2)) u_dut_a (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_a), .bus_if(if_a),
        .suit(suit_a), .rank(rank_a), .suit_score(suit_score_a), .rank_score(rank_score_a),
        .round_done_out(round_done_a), .game_over_out(game_over_a)
    );

    card_score_tracker #(.HOLD_CYCLES(1), .ROUNDS(200)) u_dut_b (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_b), .bus_if(if_b),
        .suit(suit_b), .rank(rank_b), .suit_score(suit_score_b), .rank_score(rank_score_b),
        .round_done_out(round_done_b), .game_over_out(game_over_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    initial begin
        n_pass = 0; n_total = 0; pulses = 0;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        if_a.guess_valid_in = 1'b0; if_a.guess_suit_in = 2'd0; if_a.guess_rank_in = 4'd0;
        if_a.card_valid_in = 1'b0;  if_a.card_suit_in = 2'd0;  if_a.card_rank_in = 4'd0;
        if_b.guess_valid_in = 1'b0; if_b.guess_suit_in = 2'd0; if_b.guess_rank_in = 4'd0;
        if_b.card_valid_in = 1'b0;  if_b.card_suit_in = 2'd0;  if_b.card_rank_in = 4'd0;
        #12;
        check("rst_suit", suit_a, 0);
        check("rst_rank", rank_a, 0);
        check("rst_suit_score", suit_score_a, 0);
        check("rst_rank_score", rank_score_a, 0);
        check("rst_guess_ready", if_a.guess_ready_out, 0);
        check("rst_card_ready", if_a.card_ready_out, 0);
        check("rst_round_done", round_done_a, 0);
        check("rst_game_over", game_over_a, 0);

        // Out of reset the block waits in IDLE; a guess there is ignored.
        if_a.guess_valid_in = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick(2);
        check("idle_guess_ready", if_a.guess_ready_out, 0);
        check("idle_card_ready", if_a.card_ready_out, 0);
        if_a.guess_valid_in = 1'b0;

        start_a = 1'b1; tick(1); start_a = 1'b0;
        check("start_guess_ready", if_a.guess_ready_out, 1);

        // Card held valid during GUESS must be ignored.
        if_a.card_valid_in = 1'b1; if_a.card_suit_in = 2'd2; if_a.card_rank_in = 4'd0;
        tick(2);
        check("guess_card_ignored_gr", if_a.guess_ready_out, 1);
        check("guess_card_ignored_cr", if_a.card_ready_out, 0);

        if_a.guess_valid_in = 1'b1; if_a.guess_suit_in = 2'd2; if_a.guess_rank_in = 4'd7;
        tick(1);
        if_a.guess_valid_in = 1'b0;
        check("deal_card_ready", if_a.card_ready_out, 1);
        check("deal_guess_ready", if_a.guess_ready_out, 0);

        tick(1);
        check("rank0_dropped_cr", if_a.card_ready_out, 1);
        check("rank0_dropped_rank", rank_a, 0);
        if_a.card_rank_in = 4'd14;
        tick(1);
        check("rank14_dropped_cr", if_a.card_ready_out, 1);
        check("rank14_dropped_rank", rank_a, 0);
        if_a.card_rank_in = 4'd5;
        tick(1);  // edge N: card (2,5) accepted
        check("r1_suit_at_n", suit_a, 2);
        check("r1_rank_at_n", rank_a, 5);
        check("r1_card_ready_n", if_a.card_ready_out, 0);
        if_a.card_suit_in = 2'd1; if_a.card_rank_in = 4'd9;
        tick(1);
        check("r1_score_n1", suit_score_a, 0);
        check("r1_done_n1", round_done_a, 0);
        tick(1);
        check("r1_suit_score_n2", suit_score_a, 1);
        check("r1_rank_score_n2", rank_score_a, 0);
        check("r1_done_n2", round_done_a, 1);
        tick(1);
        check("r1_done_n3", round_done_a, 0);
        check("show_card_ignored_rank", rank_a, 5);
        check("show_card_ignored_suit", suit_a, 2);
        tick(1);
        check("show_n4_guess_ready", if_a.guess_ready_out, 0);
        if_a.card_valid_in = 1'b0;
        tick(1);
        check("show_exit_guess_ready", if_a.guess_ready_out, 1);
        check("show_exit_score", suit_score_a, 1);

        // Round 2: exact (2,7) match on both fields.
        if_a.guess_valid_in = 1'b1;
        tick(1);
        if_a.guess_valid_in = 1'b0;
        if_a.card_valid_in = 1'b1; if_a.card_suit_in = 2'd2; if_a.card_rank_in = 4'd7;
        tick(1);
        if_a.card_valid_in = 1'b0;
        check("r2_suit_at_n", suit_a, 2);
        check("r2_rank_at_n", rank_a, 7);
        tick(2);
        check("r2_suit_score_n2", suit_score_a, 2);
        check("r2_rank_score_n2", rank_score_a, 1);
        check("r2_done_n2", round_done_a, 1);
        tick(2);
        check("r2_game_over_n4", game_over_a, 0);
        tick(1);
        check("r2_game_over_n5", game_over_a, 1);
        check("done_guess_ready", if_a.guess_ready_out, 0);

        if_a.guess_valid_in = 1'b1;
        tick(2);
        if_a.guess_valid_in = 1'b0;
        check("done_guess_ignored_gr", if_a.guess_ready_out, 0);
        check("done_guess_ignored_cr", if_a.card_ready_out, 0);
        check("done_still_over", game_over_a, 1);

        start_a = 1'b1; tick(1); start_a = 1'b0;
        check("restart_suit_score", suit_score_a, 0);
        check("restart_rank_score", rank_score_a, 0);
        check("restart_rank", rank_a, 0);
        check("restart_game_over", game_over_a, 0);
        check("restart_guess_ready", if_a.guess_ready_out, 1);

        // Long game on the second instance: every round matches both suit and rank.
        start_b = 1'b1; tick(1); start_b = 1'b0;
        if_b.guess_valid_in = 1'b1; if_b.guess_suit_in = 2'd3; if_b.guess_rank_in = 4'd13;
        if_b.card_valid_in = 1'b1;  if_b.card_suit_in = 2'd3;  if_b.card_rank_in = 4'd13;
        for (int c = 0; c < 1000 && pulses < 100; c++) begin
            tick(1);
            if (round_done_b) begin
                pulses++;
                if (pulses == 99) begin
                    check("b_suit_score_99", suit_score_b, 99);
                    check("b_rank_score_99", rank_score_b, 99);
                end
            end
        end
        if_b.guess_valid_in = 1'b0;
        if_b.card_valid_in = 1'b0;
        check("b_round_count_timeout", pulses, 100);
`ifdef SCORE_SATURATE_EN
        exp_limit = 7'd99;
`else
        exp_limit = 7'd0;
`endif
        check("b_suit_score_limit", suit_score_b, exp_limit);
        check("b_rank_score_limit", rank_score_b, exp_limit);

        // Reset in the middle of SHOW on instance A.
        if_a.guess_valid_in = 1'b1; if_a.guess_suit_in = 2'd1; if_a.guess_rank_in = 4'd3;
        tick(1);
        if_a.guess_valid_in = 1'b0;
        if_a.card_valid_in = 1'b1; if_a.card_suit_in = 2'd1; if_a.card_rank_in = 4'd3;
        tick(1);
        if_a.card_valid_in = 1'b0;
        tick(3);
        check("pre_rst_suit_score", suit_score_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_suit", suit_a, 0);
        check("async_rst_rank", rank_a, 0);
        check("async_rst_suit_score", suit_score_a, 0);
        check("async_rst_rank_score", rank_score_a, 0);
        check("async_rst_guess_ready", if_a.guess_ready_out, 0);
        check("async_rst_card_ready", if_a.card_ready_out, 0);
        check("async_rst_b_suit_score", suit_score_b, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);
        check("post_rst_idle", if_a.guess_ready_out, 0);
        check("post_rst_score", suit_score_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/card_score_tracker.md
CARD_SCORE_TRACKER -- requirements
Module: card_score_tracker

Interface
REQ-001 Parameter HOLD_CYCLES, default 'd100_000_000; number of cycles the revealed card is held in SHOW before the next round.
REQ-002 Parameter ROUNDS, default 'd52; rounds per game.
REQ-003 One clock, clk_in; reset rst_in is asynchronous and active-low.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  asynchronous active-low reset.
REQ-006 start_in  input  1  single-cycle pulse that starts a new game.
REQ-007 guess_valid_in  input  1  guess offered.
REQ-008 guess_suit_in  input  2  guessed suit.
REQ-009 guess_rank_in  input  4  guessed rank, 1..13.
REQ-010 guess_ready_out  output  1  high while a guess is accepted.
REQ-011 card_valid_in  input  1  dealt card offered.
REQ-012 card_suit_in  input  2  dealt suit.
REQ-013 card_rank_in  input  4  dealt rank, 1..13.
REQ-014 card_ready_out  output  1  high while a card is accepted.
REQ-015 suit  output  2  suit of last revealed card; feeds the seven-segment controller.
REQ-016 rank  output  4  rank of last revealed card; feeds the seven-segment controller.
REQ-017 suit_score  output  7  suit-match count, 0..99.
REQ-018 rank_score  output  7  rank-match count, 0..99.
REQ-019 round_done_out  output  1  one-cycle pulse when a round is scored.
REQ-020 game_over_out  output  1  high in DONE.

Function
REQ-021 States: IDLE, GUESS, DEAL, SCORE, SHOW, DONE.
REQ-022 IDLE -> GUESS on start_in. DONE -> GUESS on start_in. start_in SHALL clear scores, the round count and suit/rank on the same edge. start_in is ignored in every other state.
REQ-023 guess_ready_out = 1 only in GUESS. A guess is accepted when guess_valid_in && guess_ready_out: it is latched and the FSM moves to DEAL.
REQ-024 card_ready_out = 1 only in DEAL. A card is accepted when card_valid_in && card_ready_out && 1 <= card_rank_in <= 13; the FSM then moves to SCORE. An invalid rank (0, 14, 15) is dropped and the FSM stays in DEAL.
REQ-025 A card accepted at edge N SHALL drive suit/rank from edge N, and the FSM is in SCORE for cycle N+1.
REQ-026 SCORE lasts exactly one cycle. On exit:
  - suit_score increments if the card suit equals the latched guess suit.
  - rank_score increments if the card rank equals the latched guess rank.
  - Both scores may increment together.
  - Updated scores and the round_done_out pulse are visible from edge N+2.
REQ-027 Scores are 7-bit unsigned; the maximum value is 99 (two display digits); behaviour at 99 per REQ-036.
REQ-028 SHOW lasts exactly HOLD_CYCLES cycles, counted by a 32-bit counter cleared on entry. On exit the round count increments.
REQ-029 SHOW exit goes to DONE when the incremented round count equals ROUNDS, else to GUESS.
REQ-030 Inputs presented outside their ready state have no effect. Guesses and cards are not buffered.
REQ-031 suit, rank and the scores are stable in every state except at the update edges defined above.

Reset
REQ-032 While rst_in = 0, asynchronously: state = IDLE; suit = 0, rank = 0, suit_score = 0, rank_score = 0; latched guess, round count and hold counter = 0; all ready/pulse/flag outputs = 0.
REQ-033 Assertion of rst_in in any state, including mid-SHOW or mid-SCORE, SHALL abort the round with no score update.
REQ-034 After rst_in deasserts, the block stays in IDLE until start_in.

Configuration
REQ-035 Macro SCORE_SATURATE_EN selects the score behaviour at 99.
REQ-036 With SCORE_SATURATE_EN defined, a score at 99 holds at 99 on a match. Without it, a score at 99 wraps to 0 on a match. Both scores obey the same rule.

Verification
REQ-037 Reset asserted mid-SHOW with suit_score = 5 -> all outputs 0 and state IDLE immediately, without a clock edge.
REQ-038 start; guess (suit 2, rank 7); card (suit 2, rank 7) at edge N -> suit = 2, rank = 7 at N; suit_score = 1, rank_score = 1 and round_done_out pulse at N+2.
REQ-039 Card with rank 0, then rank 14, then rank 5 in DEAL -> only rank 5 is accepted; card_ready_out stays high until then.
REQ-040 HOLD_CYCLES = 4, ROUNDS = 2; two complete rounds -> game_over_out rises after the second SHOW; guess_valid_in is then ignored; start_in clears the scores.
REQ-041 suit_score forced to 99 by 99 matching rounds, then one more suit match -> 99 with SCORE_SATURATE_EN, 0 without.
REQ-042 card_valid_in held high during GUESS and SHOW -> no state change and no score change.
